// File: rtl/fpu_normalize_round_if.sv
// Request/response bundle between the FPU core and the normalize/round stage.
interface fpu_normalize_round_if;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [26:0] mant_in;
    logic        done_ack;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    modport master (
        output start, sign_in, exp_in, mant_in, done_ack,
        input  busy, done, result, flag_zero, flag_overflow, flag_underflow, flag_inexact
    );

    modport slave (
        input  start, sign_in, exp_in, mant_in, done_ack,
        output busy, done, result, flag_zero, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/fpu_normalize_round.sv
// Normalizes a raw add/sub sum one bit per cycle, rounds to nearest-even and
// packs an IEEE-754 single. No denormals: anything that would go subnormal is
// flushed to signed zero.
//
// state | meaning
// IDLE  | waiting for start, operands latched on start
// CHECK | classify: zero, zero exponent, carry, already normalized, needs shift
// SHIFT | one left shift per cycle until hidden bit set or exponent exhausted
// ROUND | round-to-nearest-even, exponent overflow check, pack
// DONE  | result held until done_ack
module fpu_normalize_round #(
    parameter int MAX_LSHIFT = 25
) (
    input logic               clk,
    input logic               rst_n,
    fpu_normalize_round_if.slave bus
);
    localparam int CW = $clog2(MAX_LSHIFT + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;

    state_t             state, state_nxt;
    logic               s, s_nxt;
    logic signed [9:0]  e, e_nxt;
    logic [26:0]        m, m_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [31:0]        res, res_nxt;
    logic               fz, fz_nxt, fo, fo_nxt, fu, fu_nxt, fi, fi_nxt;
    logic               go_flush;

    logic [26:0]        m_sh;
    logic signed [9:0]  e_sh;
    logic [CW-1:0]      cnt_sh;
    logic               up;
    logic [24:0]        q_sum;
    logic [22:0]        frac;
    logic signed [9:0]  e_r;

    // Shift and rounding datapath, consumed by the SHIFT and ROUND states.
    assign m_sh   = {m[25:0], 1'b0};
    assign e_sh   = e - 10'sd1;
    assign cnt_sh = cnt + CW'(1);
    assign up     = m[1] & (m[0] | m[2]);
    assign q_sum  = {1'b0, m[25:2]} + {24'd0, up};
    assign frac   = q_sum[24] ? q_sum[23:1] : q_sum[22:0];
    assign e_r    = q_sum[24] ? e + 10'sd1 : e;

    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DONE);
    assign bus.result         = res;
    assign bus.flag_zero      = fz;
    assign bus.flag_overflow  = fo;
    assign bus.flag_underflow = fu;
    assign bus.flag_inexact   = fi;

    // State, working registers and held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= 1'b0;
            e     <= '0;
            m     <= '0;
            cnt   <= '0;
            res   <= '0;
            fz    <= 1'b0;
            fo    <= 1'b0;
            fu    <= 1'b0;
            fi    <= 1'b0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            e     <= e_nxt;
            m     <= m_nxt;
            cnt   <= cnt_nxt;
            res   <= res_nxt;
            fz    <= fz_nxt;
            fo    <= fo_nxt;
            fu    <= fu_nxt;
            fi    <= fi_nxt;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        e_nxt     = e;
        m_nxt     = m;
        cnt_nxt   = cnt;
        res_nxt   = res;
        fz_nxt    = fz;
        fo_nxt    = fo;
        fu_nxt    = fu;
        fi_nxt    = fi;
        go_flush  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    s_nxt     = bus.sign_in;
                    e_nxt     = {2'b00, bus.exp_in};
                    m_nxt     = bus.mant_in;
                    cnt_nxt   = '0;
                    res_nxt   = '0;
                    fz_nxt    = 1'b0;
                    fo_nxt    = 1'b0;
                    fu_nxt    = 1'b0;
                    fi_nxt    = 1'b0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (m == 27'd0) begin
                    res_nxt   = {s, 31'd0};
                    fz_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (e == 10'sd0) begin
                    go_flush = 1'b1;
                end else if (m[26]) begin
                    // keep the dropped bit in sticky so rounding still sees it
                    m_nxt     = {1'b0, m[26:2], m[1] | m[0]};
                    e_nxt     = e + 10'sd1;
                    state_nxt = ROUND;
                end else if (m[25]) begin
                    state_nxt = ROUND;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                m_nxt   = m_sh;
                e_nxt   = e_sh;
                cnt_nxt = cnt_sh;
                if (m_sh[25]) begin
                    state_nxt = ROUND;
                end else if (e_sh == 10'sd0 || cnt_sh == CW'(MAX_LSHIFT)) begin
                    go_flush = 1'b1;
                end
            end
            ROUND: begin
                e_nxt     = e_r;
                fi_nxt    = m[1] | m[0];
                state_nxt = DONE;
                if (e_r >= 10'sd255) begin
                    res_nxt = {s, 8'hFF, 23'd0};
                    fo_nxt  = 1'b1;
                end else begin
                    res_nxt = {s, e_r[7:0], frac};
                end
            end
            DONE: begin
                if (bus.done_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (go_flush) begin
            res_nxt   = {s, 31'd0};
            fu_nxt    = 1'b1;
            fi_nxt    = 1'b1;
            state_nxt = DONE;
        end
    end
endmodule
